// File: rtl/comb_pkg.sv
// Shared constants and reference function for the DCBA combinational function.
// The truth table is indexed by {D,C,B,A}.
package comb_pkg;

    localparam logic [15:0] TRUTH = 16'hE7E2;

    function automatic logic comb_fn(input logic [3:0] idx);
        return TRUTH[idx];
    endfunction

endpackage

// File: rtl/comb_dataflow.sv
// Continuous-assignment form of the DCBA function, exposed with the legacy 5-port contract.
module comb_dataflow (
    output logic f,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    assign f = (A & ~B) | (B & C) | (~A & ~C & D);

endmodule

// File: rtl/comb_prim.sv
// Gate-primitive form of the DCBA function, exposed with the legacy 5-port contract.
module comb_prim (
    output logic f,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    comb_prim_core u_core (
        .y (f),
        .A (A),
        .B (B),
        .C (C),
        .D (D)
    );

endmodule

// File: rtl/comb_prim_core.sv
// Gate-primitive form of f = (A & ~B) | (B & C) | (~A & ~C & D).
module comb_prim_core (
    output logic y,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    logic na_s;
    logic nb_s;
    logic nc_s;
    logic t0_s;
    logic t1_s;
    logic t2_s;

    not u_na (na_s, A);
    not u_nb (nb_s, B);
    not u_nc (nc_s, C);
    and u_t0 (t0_s, A, nb_s);
    and u_t1 (t1_s, B, C);
    and u_t2 (t2_s, na_s, nc_s, D);
    or  u_or (y, t0_s, t1_s, t2_s);

endmodule

// File: rtl/comb_behavior.sv
// DCBA function computed three independent ways; f comes from the procedural form,
// f_q registers it, and mismatch latches any disagreement until reset.
module comb_behavior
    import comb_pkg::*;
(
    output logic f,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic clk,
    input  logic rst_n,
    output logic f_q,
    output logic mismatch
);

    logic pr_s;
    logic df_s;
    logic prim_s;
    logic diff_s;
    logic f_q_r;
    logic mismatch_r;

    comb_prim_core u_prim (
        .y (prim_s),
        .A (A),
        .B (B),
        .C (C),
        .D (D)
    );

    assign df_s = (A & ~B) | (B & C) | (~A & ~C & D);

    // Procedural form: minterm list, deliberately unlike the other two expressions.
    always_comb begin
        pr_s = 1'b0;
        case ({D, C, B, A})
            4'd1, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd10, 4'd13, 4'd14, 4'd15: pr_s = 1'b1;
            default:                          pr_s = 1'b0;
        endcase
    end

    assign diff_s = (pr_s ^ df_s) | (df_s ^ prim_s) | (pr_s ^ prim_s);
    assign f      = pr_s;

    // Output register and sticky disagreement flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q_r      <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            f_q_r      <= pr_s;
            mismatch_r <= mismatch_r | diff_s;
        end
    end

    assign f_q      = f_q_r;
    assign mismatch = mismatch_r;

endmodule

// File: tb/tb_comb_behavior.sv
// Scoreboard bench for comb_behavior: stimulus pushes expected registered outputs,
// a monitor pops and compares them after each rising edge.
module tb_comb_behavior;

    typedef struct {
        logic f_q;
        logic mm;
    } exp_t;

    logic clk;
    logic rst_n;
    logic A, B, C, D;
    logic f, f_q, mismatch;
    logic f_df, f_pr;

    int checks;
    int failures;
    exp_t exp_q[$];
    exp_t mon_e;
    logic exp_mm;
    logic force_val;

    comb_behavior dut (
        .f        (f),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .clk      (clk),
        .rst_n    (rst_n),
        .f_q      (f_q),
        .mismatch (mismatch)
    );

    comb_dataflow u_df (.f(f_df), .A(A), .B(B), .C(C), .D(D));
    comb_prim     u_pr (.f(f_pr), .A(A), .B(B), .C(C), .D(D));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: f is 1 exactly for the listed minterm indices of {D,C,B,A}.
    function automatic logic model(input int idx);
        int ones[10] = '{1, 5, 6, 7, 8, 9, 10, 13, 14, 15};
        for (int k = 0; k < 10; k++)
            if (ones[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, req, $time);
        end
    endtask

    // Drive a code, check the combinational outputs, queue the registered expectation.
    task automatic apply(input int idx, input logic push);
        logic m;
        {D, C, B, A} = idx[3:0];
        m = model(idx);
        #1;
        chk($sformatf("f[%0d]", idx), f, m);
        chk($sformatf("f_dataflow[%0d]", idx), f_df, m);
        chk($sformatf("f_prim[%0d]", idx), f_pr, m);
        if (push) exp_q.push_back('{f_q: m, mm: exp_mm});
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("f_q", f_q, mon_e.f_q);
            chk("mismatch", mismatch, mon_e.mm);
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        exp_mm = 1'b0;
        force_val = 1'b0;
        rst_n = 1'b0;
        {D, C, B, A} = 4'b0000;
        #2;
        chk("reset_f_q", f_q, 1'b0);
        chk("reset_mismatch", mismatch, 1'b0);
        chk("reset_f", f, 1'b0);

        // Release with 1101: first edge must load f_q=1.
        @(negedge clk);
        rst_n = 1'b1;
        apply(13, 1'b1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply(i, 1'b1);
        end

        @(negedge clk);
        apply(6, 1'b1);
        @(negedge clk);
        apply(3, 1'b1);

        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            apply(int'($urandom_range(15, 0)), 1'b1);
        end

        // Corrupt the dataflow form for one cycle; the flag must latch and stay.
        @(negedge clk);
        {D, C, B, A} = 4'b0101;
        force_val = ~model(5);
        force dut.df_s = force_val;
        exp_mm = 1'b1;
        apply(5, 1'b1);
        @(negedge clk);
        release dut.df_s;
        for (int i = 0; i < 4; i++) begin
            apply(int'($urandom_range(15, 0)), 1'b1);
            @(negedge clk);
        end

        // Async reset between edges while f_q=1.
        apply(14, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_mm = 1'b0;
        #1;
        chk("async_rst_f_q", f_q, 1'b0);
        chk("async_rst_mismatch", mismatch, 1'b0);
        chk("async_rst_f_kept", f, 1'b1);
        apply(11, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply(int'($urandom_range(15, 0)), 1'b1);
            @(negedge clk);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
